// File: rtl/pt_pkg.sv
// Shared types, frame timing constants and slot-level encoding for the PT2262 frame controller.
// Build option PT_FLOAT_EN: 16-bit trit-coded address (00=0, 11=1, 01/10=float); otherwise 8 binary address bits.
package pt_pkg;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, TF = 2'd2} trit_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BIT = 2'd1, SYNC = 2'd2} state_t;

  localparam int ALPHA_PER_BIT = 32;
  localparam int BITS_PER_WORD = 12;
  localparam int SYNC_HIGH     = 4;
  localparam int SYNC_LEN      = 128;

`ifdef PT_FLOAT_EN
  localparam int ADDR_W = 16;
`else
  localparam int ADDR_W = 8;
`endif

  // Each symbol is two 16-alpha halves; a half is either short-high (4H 12L) or long-high (12H 4L).
  function automatic logic pt_level(input trit_t t, input logic [4:0] slot);
    logic short_h;
    logic long_h;
    short_h = (slot[3:0] < 4'd4);
    long_h  = (slot[3:0] < 4'd12);
    case (t)
      T0:      pt_level = short_h;
      T1:      pt_level = long_h;
      default: pt_level = slot[4] ? long_h : short_h;
    endcase
  endfunction

endpackage

// File: rtl/pt_tick_gen.sv
// Alpha tick generator: one-clk pulse on each rising edge of the clk-synchronous oscillator.
// osc_q resets high so an oscillator that is already high after reset yields no tick.
module pt_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic osc,
  output logic tick
);

  logic osc_q;
  logic osc_d;

  always_comb osc_d = osc;

  always_ff @(posedge clk) begin
    if (rst) osc_q <= 1'b1;
    else     osc_q <= osc_d;
  end

  assign tick = osc & ~osc_q;

endmodule

// File: rtl/pt2262_frame_ctrl.sv
// PT2262-style encoder frame controller: 12 symbols (A0..A7, D0..D3) plus a 128-alpha sync per word.
// Build option PT_FLOAT_EN widens addr to 16 bits of trits; default build sends binary address symbols.
module pt2262_frame_ctrl
  import pt_pkg::*;
#(
  parameter int N_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc,
  input  logic              te_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        data,
  output logic              dout,
  output logic              busy,
  output logic              word_done,
  output state_t            dbg_state
);

  localparam logic [7:0] LAST_SLOT = 8'(ALPHA_PER_BIT - 1);
  localparam logic [3:0] LAST_SYM  = 4'(BITS_PER_WORD - 1);
  localparam logic [7:0] SYNC_END  = 8'(SYNC_LEN);
  localparam logic [7:0] SYNC_HI   = 8'(SYNC_HIGH);
  localparam logic [3:0] MIN_WORDS = 4'(N_WORDS);

  logic tick;

  state_t            state_q, state_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        alpha_cnt_q, alpha_cnt_d;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              word_done_q, word_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        data_q, data_d;
  logic              start_word;
  logic [3:0]        word_cnt_inc;

  pt_tick_gen u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .osc  (osc),
    .tick (tick)
  );

  function automatic trit_t addr_trit(input logic [ADDR_W-1:0] a, input logic [2:0] idx);
`ifdef PT_FLOAT_EN
    logic [1:0] pair;
    pair = a[{idx, 1'b0} +: 2];
    case (pair)
      2'b00:   addr_trit = T0;
      2'b11:   addr_trit = T1;
      default: addr_trit = TF;
    endcase
`else
    addr_trit = a[idx] ? T1 : T0;
`endif
  endfunction

  function automatic trit_t sym_trit(input logic [ADDR_W-1:0] a, input logic [3:0] d,
                                     input logic [3:0] idx);
    if (idx < 4'd8) sym_trit = addr_trit(a, idx[2:0]);
    else            sym_trit = d[idx[1:0]] ? T1 : T0;
  endfunction

  // alpha_cnt holds the slot to emit on the next tick; slot 0 is emitted by the tick that starts a word.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    alpha_cnt_d  = alpha_cnt_q;
    word_cnt_d   = word_cnt_q;
    dout_d       = dout_q;
    busy_d       = busy_q;
    word_done_d  = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    start_word   = 1'b0;
    word_cnt_inc = (word_cnt_q == 4'hF) ? 4'hF : word_cnt_q + 4'd1;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!te_n) begin
            start_word = 1'b1;
            word_cnt_d = 4'd0;
          end
        end
        BIT: begin
          dout_d = pt_level(sym_trit(addr_q, data_q, bit_idx_q), alpha_cnt_q[4:0]);
          if (alpha_cnt_q == LAST_SLOT) begin
            alpha_cnt_d = 8'd0;
            if (bit_idx_q == LAST_SYM) begin
              state_d   = SYNC;
              bit_idx_d = 4'd0;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end else begin
            alpha_cnt_d = alpha_cnt_q + 8'd1;
          end
        end
        SYNC: begin
          if (alpha_cnt_q == SYNC_END) begin
            word_done_d = 1'b1;
            word_cnt_d  = word_cnt_inc;
            if (word_cnt_inc >= MIN_WORDS && te_n) begin
              state_d     = IDLE;
              busy_d      = 1'b0;
              dout_d      = 1'b0;
              alpha_cnt_d = 8'd0;
            end else begin
              start_word = 1'b1;
            end
          end else begin
            dout_d      = (alpha_cnt_q < SYNC_HI);
            alpha_cnt_d = alpha_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_word) begin
      state_d     = BIT;
      busy_d      = 1'b1;
      addr_d      = addr;
      data_d      = data;
      bit_idx_d   = 4'd0;
      alpha_cnt_d = 8'd1;
      dout_d      = pt_level(sym_trit(addr, data, 4'd0), 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= 4'd0;
      alpha_cnt_q <= 8'd0;
      word_cnt_q  <= 4'd0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      alpha_cnt_q <= alpha_cnt_d;
      word_cnt_q  <= word_cnt_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;
  assign dbg_state = state_q;

endmodule
